// File: rtl/myproject_sdiv_18s_10ns_8_seq_if.sv
// myproject_sdiv_18s_10ns_8_seq_if: request/result bundle for the sequential signed divider
interface myproject_sdiv_18s_10ns_8_seq_if #(
  parameter int din0_WIDTH = 18,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 8
);
  logic start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic busy;
  logic done;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH:0] rem;
  logic ovf;
  logic dz;
  modport master(output start, din0, din1, input busy, done, dout, rem, ovf, dz);
  modport slave(input start, din0, din1, output busy, done, dout, rem, ovf, dz);
endinterface

// File: rtl/myproject_sdiv_18s_10ns_8_seq.sv
// myproject_sdiv_18s_10ns_8_seq: restoring signed/unsigned divider with saturated quotient
module myproject_sdiv_18s_10ns_8_seq #(
  parameter int ID = 1,
  parameter int din0_WIDTH = 18,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 8
) (
  input logic ap_clk,
  input logic ap_rst_n,
  myproject_sdiv_18s_10ns_8_seq_if.slave bus
);
  localparam int CW = $clog2(din0_WIDTH + 1);
  localparam logic [din0_WIDTH-1:0] plim = din0_WIDTH'((1 << (dout_WIDTH - 1)) - 1);
  localparam logic [din0_WIDTH-1:0] nlim = din0_WIDTH'(1 << (dout_WIDTH - 1));
  localparam logic [dout_WIDTH-1:0] qmax = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] qmin = {1'b1, {(dout_WIDTH-1){1'b0}}};
  if (ID < 0 || dout_WIDTH > din0_WIDTH) begin : g_bad
    $error("invalid divider parameters");
  end
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [din0_WIDTH-1:0] q;
  logic [din1_WIDTH:0] r, tr;
  logic [din1_WIDTH-1:0] d;
  logic [CW-1:0] cnt;
  logic neg, ge, last, over, dz_n;
  logic [dout_WIDTH-1:0] qs;
  assign tr = {r[din1_WIDTH-1:0], q[din0_WIDTH-1]};
  assign ge = tr >= {1'b0, d};
  assign last = cnt == CW'(din0_WIDTH);
  assign dz_n = d == '0;
  assign over = neg ? q > nlim : q > plim;
  assign qs = neg ? -q[dout_WIDTH-1:0] : q[dout_WIDTH-1:0];
  assign bus.busy = state != IDLE;
  always_comb
    state_n = (state == IDLE && bus.start) ? CALC :
              (state == CALC && last) ? FIX :
              (state == FIX) ? IDLE : state;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state <= IDLE;
      q <= '0;
      r <= '0;
      d <= '0;
      neg <= 1'b0;
      cnt <= '0;
      bus.done <= 1'b0;
      bus.dout <= '0;
      bus.rem <= '0;
      bus.ovf <= 1'b0;
      bus.dz <= 1'b0;
    end else begin
      state <= state_n;
      bus.done <= state == FIX;
      if (state == IDLE && bus.start) begin
        q <= bus.din0[din0_WIDTH-1] ? -bus.din0 : bus.din0;
        r <= '0;
        d <= bus.din1;
        neg <= bus.din0[din0_WIDTH-1];
        cnt <= '0;
      end else if (state == CALC && !last) begin
        r <= ge ? tr - {1'b0, d} : tr;
        q <= {q[din0_WIDTH-2:0], ge};
        cnt <= cnt + 1'b1;
      end
      // divide-by-zero leaves q all ones, so over must be masked for ovf
      if (state == FIX) begin
        bus.dout <= (dz_n || over) ? (neg ? qmin : qmax) : qs;
        bus.rem <= dz_n ? '0 : (neg ? -r : r);
        bus.ovf <= over && !dz_n;
        bus.dz <= dz_n;
      end
    end
endmodule

// File: doc/myproject_sdiv_18s_10ns_8_seq.md
MYPROJECT_SDIV_18S_10NS_8_SEQ -- requirements
Module: myproject_sdiv_18s_10ns_8_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 18, signed dividend width.
REQ-003 SHALL have parameter din1_WIDTH, default 10, unsigned divisor width.
REQ-004 SHALL have parameter dout_WIDTH, default 8, signed quotient width.
REQ-005 SHALL have port ap_clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port ap_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port start  input  1  request pulse; operands sampled when start=1 in IDLE.
REQ-008 SHALL have port din0  input  din0_WIDTH  signed dividend.
REQ-009 SHALL have port din1  input  din1_WIDTH  unsigned divisor (zero-extended before use).
REQ-010 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-012 SHALL have port dout  output  dout_WIDTH  signed quotient, held until the next done.
REQ-013 SHALL have port rem  output  din1_WIDTH+1  signed remainder, held until the next done.
REQ-014 SHALL have port ovf  output  1  quotient saturated; valid with dout.
REQ-015 SHALL have port dz  output  1  divide by zero; valid with dout.

Function
REQ-016 SHALL implement states IDLE, CALC, FIX, with transitions IDLE->CALC on start, CALC->FIX after din0_WIDTH iterations, and FIX->IDLE.
REQ-017 SHALL, on acceptance, latch |din0| and din1, record the dividend sign, and clear the iteration counter.
REQ-018 SHALL perform one restoring shift-subtract step per CALC cycle on unsigned magnitudes (partial remainder din1_WIDTH+1 bits), for exactly din0_WIDTH cycles.
REQ-019 SHALL, in FIX, apply signs (quotient negated if dividend<0; remainder sign follows dividend), saturate, and register dout/rem/ovf/dz with done=1 in the same edge.
REQ-020 SHALL produce done exactly din0_WIDTH+2 cycles after the accepting edge (20 with defaults); throughput is 1 result per 21 cycles minimum.
REQ-021 SHALL truncate the quotient toward zero; remainder satisfies din0 = q*din1 + rem before saturation, with |rem| < din1.
REQ-022 SHALL saturate a quotient above 2^(dout_WIDTH-1)-1 to +127 and below -2^(dout_WIDTH-1) to -128, set ovf=1, and leave rem as computed.
REQ-023 SHALL, if din1=0, output dout=+127 for din0>=0 or -128 for din0<0, rem=0, dz=1, ovf=0, with the same latency.
REQ-024 SHALL ignore start while busy=1; captured operands are never disturbed mid-operation.
REQ-025 SHALL accept start in the cycle after done (IDLE), allowing back-to-back operation.
REQ-026 SHALL handle din0=-2^17 (most negative) without magnitude overflow, using a din0_WIDTH-bit unsigned magnitude.
REQ-027 SHALL keep done low at all times except the single FIX->IDLE edge.

Reset
REQ-028 SHALL, on ap_rst_n=0 (any state, including mid-CALC), immediately force IDLE, busy=0, done=0, dout=0, rem=0, ovf=0, dz=0, and counter=0.
REQ-029 SHALL accept no start while ap_rst_n=0; the first acceptance is on the first rising edge with ap_rst_n=1 and start=1.

Verification
REQ-030 SHALL cover: din0=1000, din1=10, start for 1 cycle -> done 20 cycles later, dout=100, rem=0, ovf=0, dz=0.
REQ-031 SHALL cover: din0=-500, din1=7 -> dout=-71, rem=-3, ovf=0.
REQ-032 SHALL cover: din0=-131072, din1=1 -> dout=-128, ovf=1; then din0=2000, din1=3 -> dout=127, ovf=1, rem=2.
REQ-033 SHALL cover: din0=300, din1=0 -> dout=127, rem=0, dz=1; and din0=-5, din1=0 -> dout=-128, dz=1.
REQ-034 SHALL cover: start re-asserted with new operands on cycles 5 and 10 of a busy operation -> ignored, first result unchanged; a start on the cycle after done is accepted.
REQ-035 SHALL cover: ap_rst_n pulsed low at cycle 9 of CALC -> all outputs 0 asynchronously, no done; a fresh operation then completes with correct result and 20-cycle latency.
